// File: rtl/controlador_dupla_rampa.sv
// -----------------------------------------------------------------------------
// controlador_dupla_rampa
//
// Timing/control FSM for a dual-slope ADC. One conversion is:
//   auto-zero (T_ZERO cycles) -> integrate the unknown for exactly 1000 counts
//   -> de-integrate the reference until the integrator crosses zero
//   -> one-cycle display latch pulse.
// It drives the rst_s/enb/ld inputs of the 3-digit BCD counter and watches that
// counter's cnt_max output to time the fixed integration window and to detect
// over-range during de-integration.
//
// Parameters:
//   T_ZERO   auto-zero length in ck cycles (1 .. 2**TIMER_W-1)
//   TIMER_W  width of the auto-zero timer
//
// Ports:
//   ck       in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   inicio   in   start request, rising-edge detected
//   vint_z   in   integrator zero-crossing comparator (synchronous to ck)
//   cnt_max  in   BCD counter at 999 (wraps on the next enabled edge)
//   rst_s    out  synchronous clear to BCD counter
//   enb      out  count enable to BCD counter
//   ld       out  one-cycle display latch pulse
//   ch_zr    out  auto-zero switch
//   ch_vm    out  measured-voltage switch
//   ch_ref   out  reference-voltage switch
//   busy     out  conversion in progress
//   ovf      out  sticky over-range flag, cleared by the next accepted start
// -----------------------------------------------------------------------------
module controlador_dupla_rampa #(
    parameter int T_ZERO  = 100,
    parameter int TIMER_W = 8
) (
    input  logic ck,
    input  logic rst_n,
    input  logic inicio,
    input  logic vint_z,
    input  logic cnt_max,
    output logic rst_s,
    output logic enb,
    output logic ld,
    output logic ch_zr,
    output logic ch_vm,
    output logic ch_ref,
    output logic busy,
    output logic ovf
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ZERO  = 3'd1;
    localparam logic [2:0] S_INTEG = 3'd2;
    localparam logic [2:0] S_DEINT = 3'd3;
    localparam logic [2:0] S_LOAD  = 3'd4;

    // Timer value on the last auto-zero cycle.
    localparam logic [TIMER_W-1:0] C_TZ_LAST = TIMER_W'(T_ZERO - 1);

    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] w_timer_next;
    logic               r_inicio_d;
    logic               r_ovf;
    logic               w_ovf_next;
    logic               w_start;

    // Registered output decodes (from the next state, so they change exactly
    // with the state and carry no decode glitches).
    logic r_ch_zr;
    logic r_ch_vm;
    logic r_ch_ref;
    logic r_rst_s;
    logic r_busy;
    logic r_ld;
    logic r_enb_integ;

    assign w_start = inicio & ~r_inicio_d;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_ovf_next   = r_ovf;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_next = S_ZERO;
                    w_timer_next = '0;
                    w_ovf_next   = 1'b0;
                end
            end
            S_ZERO: begin
                if (r_timer == C_TZ_LAST) begin
                    w_state_next = S_INTEG;
                    w_timer_next = '0;
                end else begin
                    w_timer_next = r_timer + TIMER_W'(1);
                end
            end
            S_INTEG: begin
                // The counter wraps 999->000 on this same edge, so de-integration
                // starts counting from zero.
                if (cnt_max) begin
                    w_state_next = S_DEINT;
                end
            end
            S_DEINT: begin
                // Zero crossing has priority over over-range: with vint_z high the
                // count is frozen, so a simultaneous cnt_max is a valid 999.
                if (vint_z) begin
                    w_state_next = S_LOAD;
                end else if (cnt_max) begin
                    w_ovf_next   = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_LOAD: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_inicio_d  <= 1'b0;
            r_ovf       <= 1'b0;
            r_ch_zr     <= 1'b1;
            r_ch_vm     <= 1'b0;
            r_ch_ref    <= 1'b0;
            r_rst_s     <= 1'b1;
            r_busy      <= 1'b0;
            r_ld        <= 1'b0;
            r_enb_integ <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_timer     <= w_timer_next;
            r_inicio_d  <= inicio;
            r_ovf       <= w_ovf_next;
            r_ch_zr     <= (w_state_next == S_IDLE) || (w_state_next == S_ZERO) ||
                           (w_state_next == S_LOAD);
            r_ch_vm     <= (w_state_next == S_INTEG);
            r_ch_ref    <= (w_state_next == S_DEINT);
            r_rst_s     <= (w_state_next == S_IDLE) || (w_state_next == S_ZERO);
            r_busy      <= (w_state_next != S_IDLE);
            r_ld        <= (w_state_next == S_LOAD);
            r_enb_integ <= (w_state_next == S_INTEG);
        end
    end

    assign ch_zr  = r_ch_zr;
    assign ch_vm  = r_ch_vm;
    assign ch_ref = r_ch_ref;
    assign rst_s  = r_rst_s;
    assign busy   = r_busy;
    assign ld     = r_ld;
    assign ovf    = r_ovf;

    // In de-integration the enable is gated combinationally by the comparator so
    // the counter stops on the very cycle the zero crossing is seen.
    assign enb = r_enb_integ | (r_ch_ref & ~vint_z);

endmodule
